// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - ISA sizing and register transport types for the writeback arbiter
package rv32_isa;
  localparam int RegWidth     = 32;
  localparam int RegAddrWidth = 5;
  localparam int NReqDefault  = 4;
  localparam int NReqMin      = 2;
  localparam int NReqMax      = 8;
endpackage

package reg_transport;
  import rv32_isa::*;

  typedef struct packed {
    logic [RegAddrWidth-1:0] addr;
    logic [RegWidth-1:0]     value;
  } reg_transport_t;

  typedef struct packed {
    logic           valid;
    reg_transport_t rd;
  } wb_req_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - writeback request bus between requesters and the arbiter
interface rf_wb_arbiter_if #(
  parameter int N_REQ = rv32_isa::NReqDefault
);
  import reg_transport::*;

  logic                       iStall;
  logic [N_REQ-1:0]           iReqValid;
  reg_transport_t [N_REQ-1:0] iReq;
  logic [N_REQ-1:0]           oReqReady;
  logic                       oWriteEn;
  reg_transport_t             oRd;
  logic                       oBusy;

  modport master (
    output iStall, iReqValid, iReq,
    input  oReqReady, oWriteEn, oRd, oBusy
  );

  modport slave (
    input  iStall, iReqValid, iReq,
    output oReqReady, oWriteEn, oRd, oBusy
  );
endinterface

// File: rtl/rf_wb_arbiter_rr.sv
// rtl/rf_wb_arbiter_rr.sv - grant selection; RF_WB_RR_EN selects round-robin, else fixed priority
module rr_arbiter
  import rv32_isa::*;
#(
  parameter  int N_REQ = NReqDefault,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             iClk,
  input  logic             nRst,
  input  logic [N_REQ-1:0] iReq,
  input  logic             iEn,
  output logic [N_REQ-1:0] oGrant,
  output logic [IDX_W-1:0] oIdx
);

  logic [IDX_W-1:0] base;

`ifdef RF_WB_RR_EN
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] next_ptr;

  assign next_ptr = (oIdx == IDX_W'(N_REQ - 1)) ? '0 : oIdx + 1'b1;
  assign base     = ptr;

  // pointer moves one past the winner so the winner becomes lowest priority
  always_ff @(posedge iClk) begin
    if (!nRst) begin
      ptr <= '0;
    end else if (|oGrant) begin
      ptr <= next_ptr;
    end
  end
`else
  // fixed priority has no state; the clock and reset are deliberately unused
  logic unused_clk_rst;
  assign unused_clk_rst = iClk ^ nRst;
  assign base           = '0;
`endif

  // first valid requester at or after base, wrapping at N_REQ-1
  always_comb begin
    int  idx;
    logic found;
    oGrant = '0;
    oIdx   = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(base) + k) % N_REQ;
      if (iEn && !found && iReq[idx]) begin
        found       = 1'b1;
        oGrant[idx] = 1'b1;
        oIdx        = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file writeback arbiter; RF_WB_RR_EN enables round-robin
module rf_wb_arbiter
  import rv32_isa::*;
  import reg_transport::*;
#(
  parameter int N_REQ      = NReqDefault,
  parameter int REG_WIDTH  = RegWidth,
  parameter int ADDR_WIDTH = RegAddrWidth
) (
  input logic            iClk,
  input logic            nRst,
  rf_wb_arbiter_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < NReqMin || N_REQ > NReqMax) begin : g_bad_n_req
    $error("rf_wb_arbiter: N_REQ out of range");
  end
  if (REG_WIDTH != RegWidth || ADDR_WIDTH != RegAddrWidth) begin : g_bad_width
    $error("rf_wb_arbiter: widths must match reg_transport_t");
  end

  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] idx;
  logic             arb_en;
  logic             take;
  reg_transport_t   sel;
  wb_req_t          wb_q;

  // no grants while stalled or held in reset, so nothing is consumed then
  assign arb_en = ~bus.iStall & nRst;

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .iClk   (iClk),
    .nRst   (nRst),
    .iReq   (bus.iReqValid),
    .iEn    (arb_en),
    .oGrant (grant),
    .oIdx   (idx)
  );

  assign sel  = bus.iReq[idx];
  assign take = (|grant) && (sel.addr != '0);

  // one-cycle output stage; address 0 is consumed but never written
  always_ff @(posedge iClk) begin
    if (!nRst) begin
      wb_q <= '0;
    end else begin
      wb_q.valid <= take;
      if (take) begin
        wb_q.rd <= sel;
      end
    end
  end

  assign bus.oReqReady = grant;
  assign bus.oWriteEn  = wb_q.valid;
  assign bus.oRd       = wb_q.rd;
  assign bus.oBusy     = (|bus.iReqValid) | wb_q.valid;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter against a behavioural model
module tb_rf_wb_arbiter;
  import reg_transport::*;

  localparam int N = 4;

  logic iClk;
  logic nrst;
  int   checks   = 0;
  int   failures = 0;

  rf_wb_arbiter_if #(.N_REQ(N)) bus ();

  rf_wb_arbiter #(.N_REQ(N)) u_dut (
    .iClk (iClk),
    .nRst (nrst),
    .bus  (bus)
  );

  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // reference model state
  int             m_ptr;
  logic           m_we;
  reg_transport_t m_rd;
  int             last_g;
  logic [31:0]    exp_rf [32];
  logic [31:0]    dut_rf [32];

  task automatic chk(input string tag, input logic ok);
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $error("FAIL %s", tag);
    end
  endtask

  // first valid requester scanning upward from p, wrapping around
  function automatic int pick(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic cycle(input string tag);
    logic [N-1:0] er;
    int           g;
    #1;
    g  = (nrst && !bus.iStall) ? pick(bus.iReqValid, m_ptr) : -1;
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk({tag, ".rdy"}, bus.oReqReady === er);
    chk({tag, ".busy"}, bus.oBusy === ((|bus.iReqValid) | m_we));
    // register file is held in reset with the core
    if (nrst && m_we) exp_rf[m_rd.addr] = m_rd.value;
    if (nrst && bus.oWriteEn) dut_rf[bus.oRd.addr] = bus.oRd.value;
    @(posedge iClk);
    #1;
    if (!nrst) begin
      m_we  = 1'b0;
      m_rd  = '0;
      m_ptr = 0;
    end else if (g >= 0) begin
      m_we = (bus.iReq[g].addr != 0);
      if (m_we) m_rd = bus.iReq[g];
`ifdef RF_WB_RR_EN
      m_ptr = (g + 1) % N;
`endif
    end else begin
      m_we = 1'b0;
    end
    last_g = g;
    chk({tag, ".we"}, bus.oWriteEn === m_we);
    chk({tag, ".rd"}, bus.oRd === m_rd);
  endtask

  initial begin
    reg_transport_t r;
    bus.iStall    = 1'b0;
    bus.iReqValid = '0;
    bus.iReq      = '0;
    nrst          = 1'b0;
    m_ptr         = 0;
    m_we          = 1'b0;
    m_rd          = '0;
    last_g        = -1;
    for (int i = 0; i < 32; i++) begin
      exp_rf[i] = '0;
      dut_rf[i] = '0;
    end
    repeat (3) @(posedge iClk);
    #1;
    chk("rst.we", bus.oWriteEn === 1'b0);
    chk("rst.rd", bus.oRd === 37'h0);
    chk("rst.rdy", bus.oReqReady === 4'b0000);
    chk("rst.busy", bus.oBusy === 1'b0);

    // reset release with no requests
    nrst = 1'b1;
    cycle("idle");

    // single request from requester 1
    bus.iReqValid = 4'b0010;
    bus.iReq[1]   = '{addr: 5'd5, value: 32'hDEADBEEF};
    #1;
    chk("single.rdy0", bus.oReqReady === 4'b0010);
    cycle("single");
    chk("single.we1", bus.oWriteEn === 1'b1);
    chk("single.rd1", bus.oRd === {5'd5, 32'hDEADBEEF});
    bus.iReqValid = '0;
    cycle("single_hold");
    chk("single.hold", bus.oRd === {5'd5, 32'hDEADBEEF});

    // all four valid for 8 cycles from reset
    nrst = 1'b0;
    cycle("rst_a");
    nrst = 1'b1;
    for (int i = 0; i < N; i++) bus.iReq[i] = '{addr: 5'(i + 1), value: 32'h100 + i};
    bus.iReqValid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      cycle("all");
`ifdef RF_WB_RR_EN
      chk("all.order", bus.oRd.addr === 5'(c % N + 1));
`else
      chk("all.order", bus.oRd.addr === 5'd1);
`endif
    end
    bus.iReqValid = '0;
    cycle("all_end");

    // address 0 under stall
    bus.iReq[2]   = '{addr: 5'd0, value: 32'h1234};
    bus.iReqValid = 4'b0100;
    bus.iStall    = 1'b1;
    cycle("stall1");
    cycle("stall2");
    bus.iStall = 1'b0;
    #1;
    chk("zero.rdy", bus.oReqReady === 4'b0100);
    cycle("zero");
    chk("zero.we", bus.oWriteEn === 1'b0);
    bus.iReqValid = '0;
    cycle("zero_end");

    // same-address collision from ptr=0
    nrst = 1'b0;
    cycle("rst_b");
    nrst          = 1'b1;
    bus.iReq[0]   = '{addr: 5'd7, value: 32'hA};
    bus.iReq[3]   = '{addr: 5'd7, value: 32'hB};
    bus.iReqValid = 4'b1001;
    cycle("coll1");
    chk("coll.first", bus.oRd.value === 32'hA);
    bus.iReqValid = 4'b1000;
    cycle("coll2");
    chk("coll.second", bus.oRd.value === 32'hB);
    bus.iReqValid = '0;
    cycle("coll_end");
    cycle("coll_end2");
    chk("coll.rf7", dut_rf[7] === 32'hB);

    // reset immediately after a grant
    bus.iReq[1]   = '{addr: 5'd9, value: 32'h55};
    bus.iReqValid = 4'b0010;
    cycle("mid_grant");
    bus.iReqValid = '0;
    nrst          = 1'b0;
    cycle("mid_rst");
    chk("mid.we", bus.oWriteEn === 1'b0);
    nrst          = 1'b1;
    bus.iReqValid = 4'b1111;
    cycle("mid_after");
    chk("mid.ptr0", bus.oRd.addr === 5'd7);
    bus.iReqValid = '0;
    cycle("mid_end");
    chk("mid.rf9", dut_rf[9] === 32'h0);

    // randomized traffic; pending requests stay stable until granted
    for (int c = 0; c < 300; c++) begin
      bus.iStall = ($urandom_range(3) == 0);
      nrst       = ($urandom_range(59) != 0);
      for (int i = 0; i < N; i++) begin
        if (!bus.iReqValid[i] || last_g == i) begin
          bus.iReqValid[i] = $urandom_range(1);
          r.addr           = 5'($urandom_range(7));
          r.value          = $urandom;
          bus.iReq[i]      = r;
        end
      end
      cycle("rand");
    end
    bus.iReqValid = '0;
    bus.iStall    = 1'b0;
    nrst          = 1'b1;
    cycle("drain1");
    cycle("drain2");

    for (int i = 0; i < 32; i++) begin
      chk($sformatf("rf%0d", i), dut_rf[i] === exp_rf[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4; number of writeback requesters, range 2..8.
REQ-002 SHALL have parameter REG_WIDTH, default rv32_isa::RegWidth; data width.
REQ-003 SHALL have parameter ADDR_WIDTH, default rv32_isa::RegAddrWidth; register address width.
REQ-004 iClk  input  1  sole clock, all state on rising edge.
REQ-005 nRst  input  1  reset, synchronous, active-low.
REQ-006 iStall  input  1  high: no grant this cycle.
REQ-007 iReqValid  input  N_REQ  per-requester write request.
REQ-008 iReq  input  N_REQ x reg_transport_t  per-requester {addr, value}.
REQ-009 oReqReady  output  N_REQ  one-hot grant; request consumed when valid & ready in the same cycle.
REQ-010 oWriteEn  output  1  register-file write strobe.
REQ-011 oRd  output  reg_transport_t  register-file write address/data.
REQ-012 oBusy  output  1  high when any iReqValid bit is high or oWriteEn is high.

Function
REQ-013 oReqReady SHALL be combinational from iReqValid, iStall and arbitration state: at most one bit high, and never high for an invalid requester.
REQ-014 With iStall=1, oReqReady SHALL be all-zero.
REQ-015 With iStall=0 and any valid request, exactly one oReqReady bit SHALL be high (no idle cycle while requests pend).
REQ-016 A granted request SHALL appear on oRd with oWriteEn=1 exactly one cycle after the grant (registered output, latency 1).
REQ-017 oWriteEn SHALL be high for one cycle per grant; with no grant, oWriteEn=0 next cycle and oRd holds its last value.
REQ-018 A granted request with addr==0 SHALL be consumed (ready high), but the next-cycle oWriteEn SHALL be 0.
REQ-019 Requests to the same address from different requesters SHALL be serialised in grant order; the last granted value wins.
REQ-020 A requester SHALL hold iReq stable while valid and not ready; the arbiter takes no action on violations.
REQ-021 Arbitration state: a priority pointer ptr, width clog2(N_REQ). Search starts at ptr and wraps N_REQ-1 -> 0.
REQ-022 On a grant to index g, ptr SHALL become (g+1) mod N_REQ; with no grant, ptr holds.
REQ-023 Back-to-back grants SHALL sustain one write per cycle.
REQ-024 Asserting iStall SHALL NOT suppress the oWriteEn for a grant taken in the previous cycle.

Reset
REQ-025 While nRst=0 at a clock edge: oWriteEn=0, oRd={0,0}, ptr=0.
REQ-026 During reset, oReqReady SHALL be all-zero, so no request is consumed.
REQ-027 Reset on the cycle after a grant SHALL drop that pending write: oWriteEn=0 after the edge.
REQ-028 The first grant after nRst rises SHALL follow ptr=0.

Configuration
REQ-029 Macro RF_WB_RR_EN defined: round-robin per REQ-021/REQ-022.
REQ-030 Macro RF_WB_RR_EN undefined: fixed priority, lowest index wins. ptr is not implemented and REQ-022 does not apply. All other requirements are unchanged.

Structure
REQ-031 wb_req_t (valid plus reg_transport_t) SHALL live in package reg_transport.
REQ-032 N_REQ default and bounds SHALL live in package rv32_isa.
REQ-033 Grant logic SHALL be a sub-module rr_arbiter with ports:
- iClk, nRst
- iReq[N_REQ], iEn
- oGrant[N_REQ] (one-hot)
- oIdx
rr_arbiter honours RF_WB_RR_EN.
REQ-034 rf_wb_arbiter SHALL contain the output register stage and the address-0 filter.

Verification
REQ-035 Reset release, no requests: oWriteEn=0, oRd={0,0}, oReqReady=0000, oBusy=0.
REQ-036 Single request, req1 {addr 5, value 0xDEADBEEF} for one cycle: oReqReady=0010 that cycle; next cycle oWriteEn=1, oRd={5,0xDEADBEEF}.
REQ-037 Round-robin case (RF_WB_RR_EN), all four valid, held continuously for 8 cycles from reset:
- grant order 0,1,2,3,0,1,2,3;
- one write per cycle.
REQ-038 Fixed-priority case (RF_WB_RR_EN undefined), same stimulus as REQ-037: requester 0 is granted on all 8 cycles.
REQ-039 Stall and address 0:
- req2 {addr 0, value 0x1234}, iStall=1 for 2 cycles then 0: no ready during the stall; ready on cycle 3; oWriteEn stays 0 throughout.
- req0 and req3 both target addr 7 with values 0xA and 0xB, round-robin from ptr=0: writes 0xA then 0xB.
REQ-040 Reset mid-operation: grant req1 {addr 9, value 0x55}, then assert nRst=0 the following cycle: oWriteEn=0 and ptr=0 after that edge; register 9 is not written.
